// File: rtl/fft_out_serializer.sv
// Holds one 16-bin complex FFT frame and streams it out one bin per beat.
// Each bin is optionally reordered, rounded, shifted and saturated on its way out.
module fft_out_serializer #(
    parameter int INW     = 48,
    parameter int OUTW    = 16,
    parameter int SHIFT   = 0,
    parameter int REORDER = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                frame_valid,
    output logic                frame_ready,
    input  logic [16*INW-1:0]   yr_in_flat,
    input  logic [16*INW-1:0]   yi_in_flat,
    output logic                dout_valid,
    input  logic                dout_ready,
    output logic [OUTW-1:0]     dout_re,
    output logic [OUTW-1:0]     dout_im,
    output logic [3:0]          dout_idx,
    output logic                dout_last,
    output logic                sat_flag
);

    localparam logic ST_IDLE   = 1'b0;
    localparam logic ST_STREAM = 1'b1;

    localparam logic signed [INW:0] SAT_MAX = {{(INW-OUTW+2){1'b0}}, {(OUTW-1){1'b1}}};
    localparam logic signed [INW:0] SAT_MIN = {{(INW-OUTW+2){1'b1}}, {(OUTW-1){1'b0}}};
    localparam logic signed [INW:0] ROUND_ADD =
        (SHIFT > 0) ? ((INW+1)'(1) <<< ((SHIFT > 0) ? SHIFT - 1 : 0)) : '0;

    logic              r_state;
    logic [3:0]        r_n;
    logic              r_sat;
    logic [16*INW-1:0] r_yr;
    logic [16*INW-1:0] r_yi;

    logic [3:0]        w_slot;
    logic [INW-1:0]    w_binRe;
    logic [INW-1:0]    w_binIm;
    logic [OUTW:0]     w_scRe;
    logic [OUTW:0]     w_scIm;
    logic              w_beat;
    logic              w_capture;

    // Result MSB is the saturation indicator; the one extra intermediate bit keeps the rounding add from wrapping.
    function automatic logic [OUTW:0] scaleSat(input logic [INW-1:0] bin);
        logic signed [INW:0] ext;
        logic signed [INW:0] v;
        logic [OUTW:0]       res;
        ext = $signed({bin[INW-1], bin});
        v   = (ext + ROUND_ADD) >>> SHIFT;
        if (v > SAT_MAX) begin
            res = {1'b1, SAT_MAX[OUTW-1:0]};
        end else if (v < SAT_MIN) begin
            res = {1'b1, SAT_MIN[OUTW-1:0]};
        end else begin
            res = {1'b0, v[OUTW-1:0]};
        end
        return res;
    endfunction

    // Natural order undoes the radix-4 digit reversal of the FFT core.
    assign w_slot    = (REORDER != 0) ? {r_n[1:0], r_n[3:2]} : r_n;
    assign w_binRe   = r_yr[w_slot*INW +: INW];
    assign w_binIm   = r_yi[w_slot*INW +: INW];
    assign w_scRe    = scaleSat(w_binRe);
    assign w_scIm    = scaleSat(w_binIm);

    assign frame_ready = (r_state == ST_IDLE);
    assign dout_valid  = (r_state == ST_STREAM);
    assign w_capture   = frame_valid && frame_ready;
    assign w_beat      = dout_valid && dout_ready;

    assign dout_re   = w_scRe[OUTW-1:0];
    assign dout_im   = w_scIm[OUTW-1:0];
    assign dout_idx  = r_n;
    assign dout_last = dout_valid && (r_n == 4'd15);
    assign sat_flag  = r_sat;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_n     <= 4'd0;
            r_sat   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_capture) begin
                        r_state <= ST_STREAM;
                        r_n     <= 4'd0;
                        r_sat   <= 1'b0;
                    end
                end
                ST_STREAM: begin
                    if (w_beat) begin
                        r_n   <= r_n + 4'd1;
                        r_sat <= r_sat | w_scRe[OUTW] | w_scIm[OUTW];
                        if (r_n == 4'd15) begin
                            r_state <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Stored frame is cleared on reset so the outputs read zero until the next capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_yr <= '0;
            r_yi <= '0;
        end else if (w_capture) begin
            r_yr <= yr_in_flat;
            r_yi <= yi_in_flat;
        end
    end

endmodule

// File: tb/tb_fft_out_serializer.sv
// Drives three serializer configurations in lockstep and checks them every cycle against a bin-level model.
module tb_fft_out_serializer;

    localparam int INW  = 48;
    localparam int OUTW = 16;
    localparam int ND   = 3;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                frame_valid = 1'b0;
    logic                dout_ready = 1'b0;
    logic [16*INW-1:0]   yrIn = '0;
    logic [16*INW-1:0]   yiIn = '0;

    logic                fr   [ND];
    logic                dv   [ND];
    logic [OUTW-1:0]     re   [ND];
    logic [OUTW-1:0]     im   [ND];
    logic [3:0]          idx  [ND];
    logic                lst  [ND];
    logic                sf   [ND];

    int  cfgShift   [ND] = '{0, 4, 0};
    bit  cfgReorder [ND] = '{1'b1, 1'b1, 1'b0};

    longint stimRe [16];
    longint stimIm [16];

    longint mRe [16];
    longint mIm [16];
    bit     mBusy = 1'b0;
    int     mN = 0;
    bit     mSat [ND] = '{1'b0, 1'b0, 1'b0};

    int nChecks = 0;
    int nFail = 0;

    always #5 clk = ~clk;

    fft_out_serializer #(.INW(INW), .OUTW(OUTW), .SHIFT(0), .REORDER(1)) uA (
        .clk(clk), .rst_n(rst_n), .frame_valid(frame_valid), .frame_ready(fr[0]),
        .yr_in_flat(yrIn), .yi_in_flat(yiIn), .dout_valid(dv[0]), .dout_ready(dout_ready),
        .dout_re(re[0]), .dout_im(im[0]), .dout_idx(idx[0]), .dout_last(lst[0]), .sat_flag(sf[0]));

    fft_out_serializer #(.INW(INW), .OUTW(OUTW), .SHIFT(4), .REORDER(1)) uB (
        .clk(clk), .rst_n(rst_n), .frame_valid(frame_valid), .frame_ready(fr[1]),
        .yr_in_flat(yrIn), .yi_in_flat(yiIn), .dout_valid(dv[1]), .dout_ready(dout_ready),
        .dout_re(re[1]), .dout_im(im[1]), .dout_idx(idx[1]), .dout_last(lst[1]), .sat_flag(sf[1]));

    fft_out_serializer #(.INW(INW), .OUTW(OUTW), .SHIFT(0), .REORDER(0)) uC (
        .clk(clk), .rst_n(rst_n), .frame_valid(frame_valid), .frame_ready(fr[2]),
        .yr_in_flat(yrIn), .yi_in_flat(yiIn), .dout_valid(dv[2]), .dout_ready(dout_ready),
        .dout_re(re[2]), .dout_im(im[2]), .dout_idx(idx[2]), .dout_last(lst[2]), .sat_flag(sf[2]));

    function automatic longint roundShift(longint x, int sh);
        if (sh == 0) return x;
        return (x + (64'sd1 <<< (sh - 1))) >>> sh;
    endfunction

    function automatic longint satClip(longint v);
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    function automatic bit satHit(longint v);
        return (v > 32767) || (v < -32768);
    endfunction

    function automatic int slotOf(int n, bit reorder);
        return reorder ? (n % 4) * 4 + n / 4 : n;
    endfunction

    function automatic longint expRe(int d, int n);
        return satClip(roundShift(mRe[slotOf(n, cfgReorder[d])], cfgShift[d]));
    endfunction

    function automatic longint expIm(int d, int n);
        return satClip(roundShift(mIm[slotOf(n, cfgReorder[d])], cfgShift[d]));
    endfunction

    task automatic checkOutput(input string name, input int d, input longint act, input longint exp);
        nChecks++;
        if (act != exp) begin
            nFail++;
            $display("[TB] FAIL %s dut%0d at %0t: got %0d, expected %0d", name, d, $time, act, exp);
        end
    endtask

    // Reference behaviour: a captured frame plus a beat counter, advanced only by handshakes.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mBusy = 1'b0;
            mN = 0;
            for (int d = 0; d < ND; d++) mSat[d] = 1'b0;
            for (int s = 0; s < 16; s++) begin
                mRe[s] = 0;
                mIm[s] = 0;
            end
        end else if (!mBusy) begin
            if (frame_valid) begin
                for (int s = 0; s < 16; s++) begin
                    mRe[s] = $signed(yrIn[s*INW +: INW]);
                    mIm[s] = $signed(yiIn[s*INW +: INW]);
                end
                for (int d = 0; d < ND; d++) mSat[d] = 1'b0;
                mBusy = 1'b1;
                mN = 0;
            end
        end else if (dout_ready) begin
            for (int d = 0; d < ND; d++) begin
                if (satHit(roundShift(mRe[slotOf(mN, cfgReorder[d])], cfgShift[d])) ||
                    satHit(roundShift(mIm[slotOf(mN, cfgReorder[d])], cfgShift[d])))
                    mSat[d] = 1'b1;
            end
            if (mN == 15) mBusy = 1'b0;
            mN = (mN + 1) % 16;
        end
    end

    always @(negedge clk) begin
        for (int d = 0; d < ND; d++) begin
            checkOutput("dout_valid", d, longint'(dv[d]), longint'(mBusy));
            checkOutput("frame_ready", d, longint'(fr[d]), longint'(!mBusy));
            checkOutput("sat_flag", d, longint'(sf[d]), longint'(mSat[d]));
            if (mBusy) begin
                checkOutput("dout_idx", d, longint'(idx[d]), longint'(mN));
                checkOutput("dout_last", d, longint'(lst[d]), longint'(mN == 15));
                checkOutput("dout_re", d, longint'($signed(re[d])), expRe(d, mN));
                checkOutput("dout_im", d, longint'($signed(im[d])), expIm(d, mN));
            end else if (!rst_n) begin
                checkOutput("reset_re", d, longint'($signed(re[d])), 0);
                checkOutput("reset_im", d, longint'($signed(im[d])), 0);
            end
        end
    end

    task automatic packFrame();
        for (int s = 0; s < 16; s++) begin
            yrIn[s*INW +: INW] = stimRe[s][INW-1:0];
            yiIn[s*INW +: INW] = stimIm[s][INW-1:0];
        end
    endtask

    task automatic fillSeq();
        for (int s = 0; s < 16; s++) begin
            stimRe[s] = s;
            stimIm[s] = -s;
        end
    endtask

    task automatic fillSat();
        for (int s = 0; s < 16; s++) begin
            stimRe[s] = 0;
            stimIm[s] = 0;
        end
        stimRe[0] = 24;
        stimIm[0] = -24;
        stimRe[1] = 64'sd1 <<< 22;
        stimRe[2] = -(64'sd1 <<< 22);
    endtask

    function automatic longint randWord();
        longint v;
        longint edges [8] = '{32767, 32768, -32768, -32769, 524279, 524280, -524296, -524297};
        case ($urandom_range(0, 3))
            0: v = longint'($urandom_range(0, 65535)) - 32768;
            1: v = longint'($urandom_range(0, 2097151)) - 1048576;
            2: begin
                v = {$urandom(), $urandom()};
                v = (v <<< 16) >>> 16;
            end
            default: v = edges[$urandom_range(0, 7)];
        endcase
        return v;
    endfunction

    task automatic fillRand();
        for (int s = 0; s < 16; s++) begin
            stimRe[s] = randWord();
            stimIm[s] = randWord();
        end
    endtask

    task automatic driveReady(input int mode, input int cyc);
        bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        case (mode)
            0: dout_ready = 1'b1;
            1: dout_ready = pat[cyc % 4];
            default: dout_ready = 1'($urandom_range(0, 1));
        endcase
    endtask

    // mode: 0 always ready, 1 = 1,0,0,1 pattern, 2 random; pins: 1 natural-order literals, 2 saturation literals.
    task automatic applyStimulus(input int mode, input bit ignoreMode, input int pins, input int abortAt);
        int cycles = 0;
        int readyLow = 0;
        while (mBusy && cycles < 200) begin
            @(negedge clk); #1;
            cycles++;
        end
        packFrame();
        frame_valid = 1'b1;
        driveReady(mode, 0);
        @(negedge clk); #1;
        frame_valid = 1'b0;
        cycles = 0;
        while (mBusy && cycles < 200) begin
            if (fr[0] == 1'b0) readyLow++;
            if (pins == 1) begin
                if (mN == 1) begin
                    checkOutput("nat_n1_re", 0, longint'($signed(re[0])), 4);
                    checkOutput("nat_n1_im", 0, longint'($signed(im[0])), -4);
                end
                if (mN == 4) checkOutput("nat_n4_re", 0, longint'($signed(re[0])), 1);
                checkOutput("slot_order_re", 2, longint'($signed(re[2])), longint'(mN));
                checkOutput("slot_order_im", 2, longint'($signed(im[2])), -longint'(mN));
            end
            if (pins == 2) begin
                if (mN == 0) begin
                    checkOutput("round_re", 1, longint'($signed(re[1])), 2);
                    checkOutput("round_im", 1, longint'($signed(im[1])), -1);
                end
                if (mN == 4) begin
                    checkOutput("sat_hi", 1, longint'($signed(re[1])), 32767);
                    checkOutput("sat_before", 1, longint'(sf[1]), 0);
                end
                if (mN == 5) checkOutput("sat_after", 1, longint'(sf[1]), 1);
                if (mN == 8) checkOutput("sat_lo", 1, longint'($signed(re[1])), -32768);
            end
            if (mN == abortAt) begin
                rst_n = 1'b0;
                #1;
                for (int d = 0; d < ND; d++) begin
                    checkOutput("abort_valid", d, longint'(dv[d]), 0);
                    checkOutput("abort_ready", d, longint'(fr[d]), 1);
                    checkOutput("abort_sat", d, longint'(sf[d]), 0);
                    checkOutput("abort_last", d, longint'(lst[d]), 0);
                end
                @(negedge clk); #1;
                rst_n = 1'b1;
                break;
            end
            driveReady(mode, cycles + 1);
            if (ignoreMode) begin
                fillRand();
                packFrame();
                frame_valid = 1'b1;
            end
            @(negedge clk); #1;
            cycles++;
            if (!mBusy) frame_valid = 1'b0;
        end
        frame_valid = 1'b0;
        checkOutput("frame_timeout", 0, longint'(cycles >= 200), 0);
        if (pins == 1) begin
            checkOutput("ready_low_cycles", 0, longint'(readyLow), 16);
            checkOutput("ready_back", 0, longint'(fr[0]), 1);
        end
    endtask

    initial begin
        $display("[TB] starting fft_out_serializer bench");
        checkOutput("model_round_pos", -1, satClip(roundShift(24, 4)), 2);
        checkOutput("model_round_neg", -1, satClip(roundShift(-24, 4)), -1);
        checkOutput("model_sat_hi", -1, satClip(roundShift(64'sd1 <<< 22, 4)), 32767);
        checkOutput("model_sat_lo", -1, satClip(roundShift(-(64'sd1 <<< 22), 4)), -32768);
        checkOutput("model_slot_n1", -1, longint'(slotOf(1, 1'b1)), 4);
        checkOutput("model_slot_n4", -1, longint'(slotOf(4, 1'b1)), 1);

        repeat (3) @(negedge clk);
        #1;
        for (int d = 0; d < ND; d++) begin
            checkOutput("rst_valid", d, longint'(dv[d]), 0);
            checkOutput("rst_ready", d, longint'(fr[d]), 1);
            checkOutput("rst_re", d, longint'($signed(re[d])), 0);
        end
        rst_n = 1'b1;

        fillSeq();
        applyStimulus(0, 1'b0, 1, -1);
        applyStimulus(1, 1'b0, 0, -1);
        fillSat();
        applyStimulus(0, 1'b0, 2, -1);
        fillRand();
        applyStimulus(0, 1'b1, 0, -1);
        fillRand();
        applyStimulus(2, 1'b0, 0, -1);
        fillRand();
        applyStimulus(0, 1'b0, 0, 7);
        fillSeq();
        applyStimulus(0, 1'b0, 1, -1);
        for (int f = 0; f < 20; f++) begin
            fillRand();
            applyStimulus(2, f[0], 0, -1);
        end
        repeat (4) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule

// File: doc/fft_out_serializer.md
FFT_OUT_SERIALIZER -- requirements
Module: fft_out_serializer

Interface
REQ-001 Parameter INW, default 48; width of each real/imag bin word on the parallel input.
REQ-002 Parameter OUTW, default 16; width of each serial output word.
REQ-003 Parameter SHIFT, default 0; arithmetic right-shift applied to each bin before saturation, legal range 0..INW-OUTW.
REQ-004 Parameter REORDER, default 1; 1 emits bins in natural order, 0 emits bins in captured slot order.
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 rst_n  input  1  asynchronous, active-low reset.
REQ-007 frame_valid  input  1  parallel frame present on yr_in_flat/yi_in_flat.
REQ-008 frame_ready  output  1  block can accept a frame.
REQ-009 yr_in_flat  input  16*INW  signed real bins; slot s occupies bits [(s+1)*INW-1 : s*INW].
REQ-010 yi_in_flat  input  16*INW  signed imaginary bins, same packing.
REQ-011 dout_valid  output  1  serial bin valid.
REQ-012 dout_ready  input  1  downstream accepts bin.
REQ-013 dout_re  output  OUTW  signed real part of current bin.
REQ-014 dout_im  output  OUTW  signed imaginary part of current bin.
REQ-015 dout_idx  output  4  output sequence position n of current bin, 0..15.
REQ-016 dout_last  output  1  high with the bin at n=15.
REQ-017 sat_flag  output  1  sticky: some emitted component of the current frame saturated.

Function
REQ-018 Two states, IDLE and STREAM; frame_ready SHALL be 1 exactly in IDLE.
REQ-019 Capture: frame_valid&&frame_ready at an edge SHALL register all 32 input words, clear n to 0, clear sat_flag, and enter STREAM.
REQ-020 frame_valid while not in IDLE SHALL be ignored; inputs need not be held after capture.
REQ-021 dout_valid SHALL be 1 exactly in STREAM; the first bin is valid the cycle after capture (latency 1 cycle).
REQ-022 Beat handshake: dout_valid&&dout_ready at an edge SHALL advance n by 1; n, dout_re, dout_im, dout_idx, dout_last SHALL hold stable while dout_valid&&!dout_ready.
REQ-023 Handshake at n=15 SHALL return the state to IDLE; frame_ready rises the following cycle; minimum frame period 17 cycles.
REQ-024 Read slot for position n: REORDER=1 -> slot {n[1:0], n[3:2]} (radix-4 digit reversal, slot = 4*n[1:0] + n[3:2]); REORDER=0 -> slot n.
REQ-025 Scaling per component: v = bin >>> SHIFT; when SHIFT>0 add 2^(SHIFT-1) before shifting (round half up); intermediate width INW+1, no wrap.
REQ-026 Saturation: v > 2^(OUTW-1)-1 -> 2^(OUTW-1)-1; v < -2^(OUTW-1) -> -2^(OUTW-1); otherwise v truncated to OUTW bits.
REQ-027 dout_re/dout_im SHALL be combinational functions of the registered frame and n; no added latency.
REQ-028 sat_flag SHALL be set at the handshake of any beat whose real or imaginary component saturated, and cleared only by capture or reset.
REQ-029 dout_idx SHALL equal n (sequence position, not slot number).

Reset
REQ-030 rst_n low SHALL immediately force IDLE, n=0, sat_flag=0, dout_valid=0, dout_last=0, frame_ready=1, stored frame to zero (dout_re=dout_im=0).
REQ-031 Reset mid-STREAM SHALL abort the frame; no further beats of that frame are emitted after reset release.
REQ-032 First capture is possible at the first rising edge with rst_n high.

Verification
REQ-033 Scenario natural order: REORDER=1, SHIFT=0, slot s real=s, imag=-s, dout_ready=1 -> 16 beats; n=1 gives re=4, im=-4; n=4 gives re=1; dout_last only at n=15; frame_ready high 17 cycles after capture.
REQ-034 Scenario backpressure: dout_ready toggles 1,0,0,1 pattern -> outputs frozen in stall cycles, no beat lost or duplicated, order 0..15 intact.
REQ-035 Scenario saturation/rounding: SHIFT=4, OUTW=16, slot0 real=24 (-> 2), slot0 imag=-24 (-> -1), slot1 real=2^22 (-> 32767), slot2 real=-2^22 (-> -32768) -> sat_flag set after slot1 beat, cleared by next capture.
REQ-036 Scenario ignore: frame_valid held high during STREAM with changing data -> emitted values equal first captured frame; second frame captured only from IDLE.
REQ-037 Scenario reset mid-frame: rst_n low at n=7 -> dout_valid=0, frame_ready=1, sat_flag=0 asynchronously; next frame starts at n=0.
REQ-038 Scenario REORDER=0: same stimulus as REQ-033 -> beat n has re=n, im=-n.
